// File: rtl/idu_is_pipe0_iq.sv
// Pipe0 ALU issue queue: holds dispatched instructions, wakes their sources from CDB/RF forward, issues one ready entry per cycle.
// Optional macro IDU_IS_PIPE0_AGE_SELECT_EN: defined -> oldest ready entry issues (age matrix); undefined -> lowest-index ready entry issues.
module idu_is_pipe0_iq #(
    parameter int IQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_clk,
    input  logic        rtu_global_flush,
    input  logic        idu_is_dp_vld,
    input  logic [3:0]  idu_is_dp_iid,
    input  logic [6:0]  idu_is_dp_opcode,
    input  logic [6:0]  idu_is_dp_funct7,
    input  logic [2:0]  idu_is_dp_funct3,
    input  logic [63:0] idu_is_dp_pc,
    input  logic        idu_is_dp_psrc1_vld,
    input  logic [5:0]  idu_is_dp_psrc1,
    input  logic        idu_is_dp_psrc1_rdy,
    input  logic        idu_is_dp_psrc2_vld,
    input  logic [5:0]  idu_is_dp_psrc2,
    input  logic        idu_is_dp_psrc2_rdy,
    input  logic        idu_is_dp_pdst_vld,
    input  logic [5:0]  idu_is_dp_pdst,
    input  logic        idu_is_dp_imm_vld,
    input  logic [63:0] idu_is_dp_imm,
    output logic        idu_is_dp_ready,
    input  logic        exu_idu_is_alu_cdb_vld,
    input  logic [5:0]  exu_idu_is_alu_cdb_preg,
    input  logic        exu_idu_is_mxu_cdb_vld,
    input  logic [5:0]  exu_idu_is_mxu_cdb_preg,
    input  logic        exu_idu_is_div_cdb_vld,
    input  logic [5:0]  exu_idu_is_div_cdb_preg,
    input  logic        exu_idu_is_lsu_cdb_vld,
    input  logic [5:0]  exu_idu_is_lsu_cdb_preg,
    input  logic        idu_idu_is_alu_rf_forward_vld,
    input  logic [5:0]  idu_idu_is_alu_rf_forward_preg,
    output logic        idu_idu_rf_pipe0_vld,
    output logic [3:0]  idu_idu_rf_pipe0_iid,
    output logic [6:0]  idu_idu_rf_pipe0_opcode,
    output logic [6:0]  idu_idu_rf_pipe0_funct7,
    output logic [2:0]  idu_idu_rf_pipe0_funct3,
    output logic [63:0] idu_idu_rf_pipe0_pc,
    output logic        idu_idu_rf_pipe0_psrc1_vld,
    output logic [5:0]  idu_idu_rf_pipe0_psrc1,
    output logic        idu_idu_rf_pipe0_psrc2_vld,
    output logic [5:0]  idu_idu_rf_pipe0_psrc2,
    output logic        idu_idu_rf_pipe0_pdst_vld,
    output logic [5:0]  idu_idu_rf_pipe0_pdst,
    output logic        idu_idu_rf_pipe0_imm_vld,
    output logic [63:0] idu_idu_rf_pipe0_imm
);

    localparam int IDX_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(IQ_DEPTH);

    // Dispatch handshake: an instruction transfers on a rising edge where idu_is_dp_vld
    // and idu_is_dp_ready are both high and no flush is asserted; ready never looks at vld.
    // The issue bus has no back-pressure: the RF stage takes every cycle where vld=1.

    logic [IQ_DEPTH-1:0] r_vld;
    logic [IQ_DEPTH-1:0] r_rdy1;
    logic [IQ_DEPTH-1:0] r_rdy2;
    logic [IQ_DEPTH-1:0] r_psrc1_vld;
    logic [IQ_DEPTH-1:0] r_psrc2_vld;
    logic [IQ_DEPTH-1:0] r_pdst_vld;
    logic [IQ_DEPTH-1:0] r_imm_vld;
    logic [3:0]          r_iid    [IQ_DEPTH];
    logic [6:0]          r_opcode [IQ_DEPTH];
    logic [6:0]          r_funct7 [IQ_DEPTH];
    logic [2:0]          r_funct3 [IQ_DEPTH];
    logic [63:0]         r_pc     [IQ_DEPTH];
    logic [5:0]          r_psrc1  [IQ_DEPTH];
    logic [5:0]          r_psrc2  [IQ_DEPTH];
    logic [5:0]          r_pdst   [IQ_DEPTH];
    logic [63:0]         r_imm    [IQ_DEPTH];
    logic [CNT_W-1:0]    r_cnt;

    logic [63:0]         w_wake_vec;
    logic [IQ_DEPTH-1:0] w_cand;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_issue;
    logic                w_accept;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // One bit per physical register woken this cycle, from any CDB or the RF forward.
    always_comb begin
        w_wake_vec = '0;
        if (exu_idu_is_alu_cdb_vld)        w_wake_vec[exu_idu_is_alu_cdb_preg]        = 1'b1;
        if (exu_idu_is_mxu_cdb_vld)        w_wake_vec[exu_idu_is_mxu_cdb_preg]        = 1'b1;
        if (exu_idu_is_div_cdb_vld)        w_wake_vec[exu_idu_is_div_cdb_preg]        = 1'b1;
        if (exu_idu_is_lsu_cdb_vld)        w_wake_vec[exu_idu_is_lsu_cdb_preg]        = 1'b1;
        if (idu_idu_is_alu_rf_forward_vld) w_wake_vec[idu_idu_is_alu_rf_forward_preg] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_cand[i] = r_vld[i] & (~r_psrc1_vld[i] | r_rdy1[i]) & (~r_psrc2_vld[i] | r_rdy2[i]);
        end
    end

`ifdef IDU_IS_PIPE0_AGE_SELECT_EN
    // r_age[i][j] = entry i is older than entry j; only meaningful when both are valid.
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] r_age;
    logic [IQ_DEPTH-1:0]               w_blocked;

    always_comb begin
        w_sel_idx = '0;
        w_blocked = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            for (int j = 0; j < IQ_DEPTH; j++) begin
                if (j != i && w_cand[j] && r_age[j][i]) w_blocked[i] = 1'b1;
            end
            if (w_cand[i] && !w_blocked[i]) w_sel_idx = IDX_W'(i);
        end
    end
`else
    always_comb begin
        w_sel_idx = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (w_cand[i]) w_sel_idx = IDX_W'(i);
        end
    end
`endif

    // Free-slot search sees registered valid bits only, so a slot freed by this cycle's issue is not reused.
    always_comb begin
        w_free_idx = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (!r_vld[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign idu_is_dp_ready = (r_cnt != FULL);
    assign w_issue         = (|w_cand) & ~rtu_global_flush;
    assign w_accept        = idu_is_dp_vld & idu_is_dp_ready & ~rtu_global_flush;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_accept && !w_issue && r_cnt != FULL) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_issue && !w_accept && r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        idu_idu_rf_pipe0_vld       = w_issue;
        idu_idu_rf_pipe0_iid       = '0;
        idu_idu_rf_pipe0_opcode    = '0;
        idu_idu_rf_pipe0_funct7    = '0;
        idu_idu_rf_pipe0_funct3    = '0;
        idu_idu_rf_pipe0_pc        = '0;
        idu_idu_rf_pipe0_psrc1_vld = 1'b0;
        idu_idu_rf_pipe0_psrc1     = '0;
        idu_idu_rf_pipe0_psrc2_vld = 1'b0;
        idu_idu_rf_pipe0_psrc2     = '0;
        idu_idu_rf_pipe0_pdst_vld  = 1'b0;
        idu_idu_rf_pipe0_pdst      = '0;
        idu_idu_rf_pipe0_imm_vld   = 1'b0;
        idu_idu_rf_pipe0_imm       = '0;
        if (w_issue) begin
            idu_idu_rf_pipe0_iid       = r_iid[w_sel_idx];
            idu_idu_rf_pipe0_opcode    = r_opcode[w_sel_idx];
            idu_idu_rf_pipe0_funct7    = r_funct7[w_sel_idx];
            idu_idu_rf_pipe0_funct3    = r_funct3[w_sel_idx];
            idu_idu_rf_pipe0_pc        = r_pc[w_sel_idx];
            idu_idu_rf_pipe0_psrc1_vld = r_psrc1_vld[w_sel_idx];
            idu_idu_rf_pipe0_psrc1     = r_psrc1[w_sel_idx];
            idu_idu_rf_pipe0_psrc2_vld = r_psrc2_vld[w_sel_idx];
            idu_idu_rf_pipe0_psrc2     = r_psrc2[w_sel_idx];
            idu_idu_rf_pipe0_pdst_vld  = r_pdst_vld[w_sel_idx];
            idu_idu_rf_pipe0_pdst      = r_pdst[w_sel_idx];
            idu_idu_rf_pipe0_imm_vld   = r_imm_vld[w_sel_idx];
            idu_idu_rf_pipe0_imm       = r_imm[w_sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_clk) begin
            r_vld  <= '0;
            r_cnt  <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
`ifdef IDU_IS_PIPE0_AGE_SELECT_EN
            r_age  <= '0;
`endif
        end else if (rtu_global_flush) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (r_vld[i] && w_wake_vec[r_psrc1[i]]) r_rdy1[i] <= 1'b1;
                if (r_vld[i] && w_wake_vec[r_psrc2[i]]) r_rdy2[i] <= 1'b1;
            end
            if (w_issue) r_vld[w_sel_idx] <= 1'b0;
            if (w_accept) begin
                r_vld[w_free_idx]       <= 1'b1;
                r_iid[w_free_idx]       <= idu_is_dp_iid;
                r_opcode[w_free_idx]    <= idu_is_dp_opcode;
                r_funct7[w_free_idx]    <= idu_is_dp_funct7;
                r_funct3[w_free_idx]    <= idu_is_dp_funct3;
                r_pc[w_free_idx]        <= idu_is_dp_pc;
                r_psrc1_vld[w_free_idx] <= idu_is_dp_psrc1_vld;
                r_psrc1[w_free_idx]     <= idu_is_dp_psrc1;
                r_psrc2_vld[w_free_idx] <= idu_is_dp_psrc2_vld;
                r_psrc2[w_free_idx]     <= idu_is_dp_psrc2;
                r_pdst_vld[w_free_idx]  <= idu_is_dp_pdst_vld;
                r_pdst[w_free_idx]      <= idu_is_dp_pdst;
                r_imm_vld[w_free_idx]   <= idu_is_dp_imm_vld;
                r_imm[w_free_idx]       <= idu_is_dp_imm;
                r_rdy1[w_free_idx]      <= idu_is_dp_psrc1_rdy | w_wake_vec[idu_is_dp_psrc1];
                r_rdy2[w_free_idx]      <= idu_is_dp_psrc2_rdy | w_wake_vec[idu_is_dp_psrc2];
`ifdef IDU_IS_PIPE0_AGE_SELECT_EN
                // Newcomer is younger than every resident entry.
                for (int j = 0; j < IQ_DEPTH; j++) begin
                    r_age[w_free_idx][j] <= 1'b0;
                    if (IDX_W'(j) != w_free_idx) r_age[j][w_free_idx] <= 1'b1;
                end
`endif
            end
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
